// File: rtl/seq_multiplier.sv
// seq_multiplier: 32x32 -> 64 shift-and-add multiplier.
// One bit of the multiplier is processed per cycle, and all additions go
// through a single 32-bit carry-lookahead adder (cla32, defined below).
// Optional feature macro: MUL_SIGNED_EN. When it is defined, the block adds
// the is_signed port and a FIX state that negates the product. When it is
// undefined, the block does unsigned multiplication only.

// cla32: 32-bit carry-lookahead adder. It is built from eight 4-bit lookahead
// groups, and carries ripple between the groups.
module cla32 (
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] g;
   logic [31:0] p;
   logic [31:0] c;
   logic [7:0]  grp_g;
   logic [7:0]  grp_p;
   logic [8:0]  grp_c;

   assign g        = x & y;
   assign p        = x ^ y;
   assign grp_c[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_grp
         localparam int B = 4 * gi;
         assign c[B]     = grp_c[gi];
         assign c[B+1]   = g[B] | (p[B] & grp_c[gi]);
         assign c[B+2]   = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[gi]);
         assign c[B+3]   = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                         | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);
         assign grp_p[gi] = &p[B+3:B];
         assign grp_g[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B]);
         assign grp_c[gi+1] = grp_g[gi] | (grp_p[gi] & grp_c[gi]);
      end
   endgenerate

   assign sum  = p ^ c;
   assign cout = grp_c[8];

endmodule

module seq_multiplier (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
`ifdef MUL_SIGNED_EN
   input  logic        is_signed,
`endif
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [63:0] prod
);

`ifdef MUL_SIGNED_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd3} state_t;
`endif

   state_t      state_reg;
   state_t      state_next;

   logic [31:0] mcand_reg;
   logic [31:0] hi_reg;
   logic [31:0] mq_reg;
   logic        carry_reg;
   logic [5:0]  count_reg;
   logic [63:0] prod_reg;
`ifdef MUL_SIGNED_EN
   logic        neg_reg;
   logic [31:0] neg_hi;
`endif

   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic        neg_in;
   logic        iter_done;
   logic        fix_needed;

   logic [31:0] add_x;
   logic [31:0] add_y;
   logic        add_cin;
   logic [31:0] add_sum;
   logic        add_cout;

   logic        acc_carry;
   logic [31:0] acc_hi;

   // Operand conditioning at latch time. In signed mode the operands are
   // replaced by their magnitudes. The magnitude of 0x80000000 is 0x80000000,
   // read as an unsigned value.
   always_comb begin
      mag_a  = a;
      mag_b  = b;
      neg_in = 1'b0;
`ifdef MUL_SIGNED_EN
      if (is_signed) begin
         if (a[31]) mag_a = ~a + 32'd1;
         if (b[31]) mag_b = ~b + 32'd1;
         neg_in = a[31] ^ b[31];
      end
`endif
   end

   // The 33rd RUN cycle does no arithmetic. It only sees the finished count
   // and chooses the exit state.
   assign iter_done = count_reg[5];

`ifdef MUL_SIGNED_EN
   // A zero magnitude product needs no negation, even if the signs differ.
   assign fix_needed = neg_reg & (|{hi_reg, mq_reg});
`else
   assign fix_needed = 1'b0;
`endif

   // Adder operand steering. In RUN the adder computes hi + mcand. In FIX it
   // forms the low half of the 64-bit negation as ~mq + 1.
   always_comb begin
      add_x   = hi_reg;
      add_y   = mcand_reg;
      add_cin = 1'b0;
`ifdef MUL_SIGNED_EN
      if (state_reg == FIX) begin
         add_x   = ~mq_reg;
         add_y   = 32'd0;
         add_cin = 1'b1;
      end
`endif
   end

   cla32 u_add (
      .x    (add_x),
      .y    (add_y),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

`ifdef MUL_SIGNED_EN
   // The high half of the negation takes in the carry from the low half.
   assign neg_hi = ~hi_reg + {31'd0, add_cout};
`endif

   // Partial-product step. The sum is used only when the current multiplier
   // bit is set. Otherwise the accumulator passes through unchanged.
   always_comb begin
      acc_carry = carry_reg;
      acc_hi    = hi_reg;
      if (mq_reg[0]) begin
         acc_carry = add_cout;
         acc_hi    = add_sum;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic and status outputs
   always_comb begin
      state_next = state_reg;
      ready      = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            ready = 1'b1;
            busy  = 1'b0;
            if (start) state_next = RUN;
         end
         RUN: begin
`ifdef MUL_SIGNED_EN
            if (iter_done) state_next = fix_needed ? FIX : DONE;
`else
            if (iter_done) state_next = DONE;
`endif
         end
`ifdef MUL_SIGNED_EN
         FIX: state_next = DONE;
`endif
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers. These are the operand latch, the shift/accumulate
   // step and the product write on entry to DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_reg <= 32'd0;
         hi_reg    <= 32'd0;
         mq_reg    <= 32'd0;
         carry_reg <= 1'b0;
         count_reg <= 6'd0;
         prod_reg  <= 64'd0;
`ifdef MUL_SIGNED_EN
         neg_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  mcand_reg <= mag_a;
                  mq_reg    <= mag_b;
                  hi_reg    <= 32'd0;
                  carry_reg <= 1'b0;
                  count_reg <= 6'd0;
`ifdef MUL_SIGNED_EN
                  neg_reg   <= neg_in;
`endif
               end
            end
            RUN: begin
               if (!iter_done) begin
                  carry_reg <= 1'b0;
                  hi_reg    <= {acc_carry, acc_hi[31:1]};
                  mq_reg    <= {acc_hi[0], mq_reg[31:1]};
                  count_reg <= count_reg + 6'd1;
               end else if (!fix_needed) begin
                  prod_reg <= {hi_reg, mq_reg};
               end
            end
`ifdef MUL_SIGNED_EN
            FIX: prod_reg <= {neg_hi, add_sum};
`endif
            default: ;
         endcase
      end
   end

   assign prod = prod_reg;

   // neg_in is used only in the signed build.
   logic unused_ok;
   assign unused_ok = neg_in;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier. It covers the unsigned path and
// timing, held start, reset abort and reset priority. When MUL_SIGNED_EN is
// defined it also covers the signed cases.
`timescale 1ns/1ps
module tb_seq_multiplier;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
`ifdef MUL_SIGNED_EN
   logic        is_signed;
`endif
   logic        ready;
   logic        busy;
   logic        done;
   logic [63:0] prod;

   int checks = 0;
   int errors = 0;

   seq_multiplier dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
`ifdef MUL_SIGNED_EN
      .is_signed (is_signed),
`endif
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .prod      (prod)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%016h", tag, got);
      end
   endtask

   // Pulse start for one edge, then count cycles until done (bounded).
   task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic sgn, output int lat);
      @(negedge clk);
      a = op_a;
      b = op_b;
`ifdef MUL_SIGNED_EN
      is_signed = sgn;
`else
      if (sgn) $display("note: signed request run as unsigned");
`endif
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic check_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                           input logic sgn, input logic [63:0] exp_prod, input int exp_lat);
      int lat;
      run_op(op_a, op_b, sgn, lat);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " prod"}, prod, exp_prod);
      @(posedge clk);
      #1;
      check({tag, " done_drop"}, {63'd0, done}, 64'd0);
      check({tag, " ready_back"}, {63'd0, ready}, 64'd1);
      check({tag, " prod_hold"}, prod, exp_prod);
   endtask

   initial begin
      int dn;
      int rd;
      int wt;
      rst_n = 1'b0;
      start = 1'b0;
      a     = 32'd0;
      b     = 32'd0;
`ifdef MUL_SIGNED_EN
      is_signed = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("reset ready", {63'd0, ready}, 64'd1);
      check("reset busy",  {63'd0, busy},  64'd0);
      check("reset done",  {63'd0, done},  64'd0);
      check("reset prod",  prod,           64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      check_op("7x6",        32'd7,          32'd6,          1'b0, 64'h0000_0000_0000_002A, 33);
      check_op("max x max",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001, 33);
      check_op("0 x b",      32'd0,          32'h1234_5678,  1'b0, 64'd0,                  33);
      check_op("max x 2",    32'hFFFF_FFFF,  32'd2,          1'b0, 64'h0000_0001_FFFF_FFFE, 33);
      check_op("2^16 sq",    32'h0001_0000,  32'h0001_0000,  1'b0, 64'h0000_0001_0000_0000, 33);
      check_op("1 x max",    32'd1,          32'hFFFF_FFFF,  1'b0, 64'h0000_0000_FFFF_FFFF, 33);

      // Hold start for 40 cycles. Expect one done, then exactly one IDLE
      // cycle. That IDLE cycle shows that start was ignored during DONE.
      @(negedge clk);
      a = 32'd3;
      b = 32'd5;
      start = 1'b1;
      dn = 0;
      rd = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done)  dn++;
         if (ready) rd++;
      end
      start = 1'b0;
      check("held done count",  64'(dn), 64'd1);
      check("held ready count", 64'(rd), 64'd1);
      check("held prod",        prod,    64'd15);
      wt = 0;
      while (!done && wt < 100) begin
         @(posedge clk);
         #1 wt++;
      end
      check("held second done", {63'd0, done}, 64'd1);
      check("held second prod", prod, 64'd15);
      @(posedge clk);
      #1;

      // Reset at RUN iteration 10
      @(negedge clk);
      a = 32'd5;
      b = 32'd5;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort done",  {63'd0, done},  64'd0);
      check("abort ready", {63'd0, ready}, 64'd1);
      check("abort busy",  {63'd0, busy},  64'd0);
      check("abort prod",  prod,           64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) dn++;
      end
      check("abort no done", 64'(dn), 64'd0);
      check("abort prod after", prod, 64'd0);

      // Reset and start in the same cycle
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b1;
      a = 32'd7;
      b = 32'd6;
      @(posedge clk);
      #1;
      check("rst prio ready", {63'd0, ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("rst prio idle", {63'd0, busy}, 64'd0);

      check_op("after reset 7x6", 32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 33);

`ifdef MUL_SIGNED_EN
      check_op("s -3x7",      32'hFFFF_FFFD, 32'd7,          1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 34);
      check_op("s min x min", 32'h8000_0000, 32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000, 33);
      check_op("s -1x0",      32'hFFFF_FFFF, 32'd0,          1'b1, 64'd0,                  33);
      check_op("s -5x-5",     32'hFFFF_FFFB, 32'hFFFF_FFFB,  1'b1, 64'd25,                 33);
      check_op("s 3x-4",      32'd3,         32'hFFFF_FFFC,  1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 34);
      check_op("u 0xFFFFFFFDx7", 32'hFFFF_FFFD, 32'd7,       1'b0, 64'h0000_0006_FFFF_FFEB, 33);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32, product width 64.
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request; accepted only when ready=1.
REQ-005 SHALL have port: a  input  32  multiplicand, sampled on accepted start.
REQ-006 SHALL have port: b  input  32  multiplier, sampled on accepted start.
REQ-007 SHALL have port: is_signed  input  1  two's-complement mode, sampled on accepted start; present only with MUL_SIGNED_EN.
REQ-008 SHALL have port: ready  output  1  high in IDLE only.
REQ-009 SHALL have port: busy  output  1  high in every non-IDLE state.
REQ-010 SHALL have port: done  output  1  single-cycle pulse when the product becomes valid.
REQ-011 SHALL have port: prod  output  64  product, registered.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX, DONE, with FIX present only with MUL_SIGNED_EN.
REQ-013 IDLE + start: latch operands, clear accumulator hi[31:0] and carry, load mq=b (or |b|), count=0, go RUN.
REQ-014 RUN, each cycle: if mq[0]=1, {carry,hi} = hi + mcand through one instance of the team's 32-bit CLA adder (Cin=0); otherwise add nothing.
REQ-015 RUN, same cycle: shift {carry,hi,mq} right by 1 and increment count.
REQ-016 RUN exit: after exactly 32 iterations (count 31 processed), go DONE, or go FIX if a negate is pending.
REQ-017 FIX: prod = two's-complement negation of {hi,mq} over 64 bits (low 32 bits with Cin=1, high 32 bits with the low-half carry), then go DONE.
REQ-018 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-019 prod SHALL be written only on the transition into DONE and held stable until the next accepted start's DONE.
REQ-020 start SHALL be ignored while busy=1, including a start asserted in the DONE cycle.
REQ-021 Latency: start sampled at edge N yields done=1 in the cycle after edge N+33 (unsigned) or N+34 (signed with a negative result).
REQ-022 A zero operand SHALL still take the full 32 iterations (no early termination) and produce prod=0.
REQ-023 Unsigned 0xFFFFFFFF x 0xFFFFFFFF SHALL yield 0xFFFFFFFE00000001; carry out of hi is never lost.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force IDLE, prod=0, done=0, busy=0, ready=1, and count, hi, mq and carry all 0.
REQ-025 Reset mid-operation SHALL abort the operation without asserting done; prod reads 0 afterwards.
REQ-026 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-027 Macro MUL_SIGNED_EN defined: is_signed port exists; with is_signed=1, operands are replaced by magnitudes at latch time.
REQ-028 Macro MUL_SIGNED_EN defined: neg = a[31]^b[31] is latched, FIX runs only when neg=1 and the product is nonzero, and |0x80000000| = 0x80000000 unsigned.
REQ-029 Macro MUL_SIGNED_EN defined: with is_signed=0, behaviour is identical to the unsigned path.
REQ-030 Macro MUL_SIGNED_EN undefined: no is_signed port, no FIX state, unsigned multiply only.

Verification
REQ-031 a=7, b=6, start pulse -> done once after 33 cycles, prod=0x000000000000002A, ready back to 1 the next cycle.
REQ-032 a=0xFFFFFFFF, b=0xFFFFFFFF -> prod=0xFFFFFFFE00000001; a=0, b=0x12345678 -> prod=0, still 33-cycle latency.
REQ-033 start held high for 40 cycles with a=3, b=5 -> exactly one accepted operation; a second op starts only from IDLE; prod=15.
REQ-034 rst_n=0 at RUN iteration 10 of a=5, b=5 -> no done pulse, prod=0, ready=1 on the next cycle.
REQ-035 With MUL_SIGNED_EN: a=-3, b=7, is_signed=1 -> prod=0xFFFFFFFFFFFFFFEB after 34 cycles.
REQ-036 With MUL_SIGNED_EN: a=b=0x80000000, is_signed=1 -> prod=0x4000000000000000.
REQ-037 With MUL_SIGNED_EN: a=-1, b=0, is_signed=1 -> prod=0 with no FIX cycle.
